// File: rtl/i2c_master.sv
// Single-master I2C controller: one single-byte write or read per command, open-drain
// SCL/SDA enables, slave clock stretching honoured and slave ACK/NACK reported.
module i2c_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [6:0] addr_i,
    input  logic       rnw_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       nack_o,
    input  logic       scl_i,
    output logic       scl_o,
    input  logic       sda_i,
    output logic       sda_o
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] Q_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE
    } state_t;

    state_t        state;
    state_t        nstate;
    logic [CW-1:0] qcnt;
    logic [1:0]    quarter;
    logic [1:0]    nquarter;
    logic [2:0]    bit_idx;
    logic [2:0]    nbit;
    logic [7:0]    tx_addr;
    logic [7:0]    tx_data;
    logic [7:0]    rx_shift;
    logic          rnw;
    logic          sda_smp;
    logic          slot;
    logic          stall;
    logic          q_wrap;
    logic          nsda_bit;

    // {scl, sda} levels for a given position in the transaction (1 = release).
    function automatic logic [1:0] drive(state_t s, logic [1:0] q, logic b);
        logic [1:0] lv;
        case (s)
            START:              lv = (q == 2'd0) ? 2'b11 : ((q == 2'd3) ? 2'b00 : 2'b10);
            ADDR, DATA:         lv = {q[1], b};
            ADDR_ACK, DATA_ACK: lv = {q[1], 1'b1};
            STOP:               lv = (q == 2'd0) ? 2'b00 : ((q == 2'd3) ? 2'b11 : 2'b10);
            default:            lv = 2'b11;
        endcase
        return lv;
    endfunction

    // Position the sequencer moves to when the current quarter ends.
    always_comb begin
        slot     = (state == ADDR) || (state == ADDR_ACK) || (state == DATA) || (state == DATA_ACK);
        stall    = ((slot && quarter == 2'd2) || (state == STOP && quarter == 2'd1)) && !scl_i;
        q_wrap   = (qcnt == Q_LAST) && !stall;
        nstate   = state;
        nquarter = quarter;
        nbit     = bit_idx;
        if (q_wrap && state != IDLE && state != DONE) begin
            nquarter = quarter + 2'd1;
            if (quarter == 2'd3) begin
                case (state)
                    START:    begin nstate = ADDR; nbit = 3'd7; end
                    ADDR:     if (bit_idx == 3'd0) nstate = ADDR_ACK; else nbit = bit_idx - 3'd1;
                    ADDR_ACK: if (sda_smp) nstate = STOP; else begin nstate = DATA; nbit = 3'd7; end
                    DATA:     if (bit_idx == 3'd0) nstate = DATA_ACK; else nbit = bit_idx - 3'd1;
                    DATA_ACK: nstate = STOP;
                    STOP:     nstate = DONE;
                    default:  nstate = state;
                endcase
            end
        end
        nsda_bit = (nstate == ADDR) ? tx_addr[nbit] : (rnw | tx_data[nbit]);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= IDLE;
            qcnt     <= '0;
            quarter  <= 2'd0;
            bit_idx  <= 3'd0;
            tx_addr  <= 8'h00;
            tx_data  <= 8'h00;
            rx_shift <= 8'h00;
            rnw      <= 1'b0;
            sda_smp  <= 1'b0;
            rdata_o  <= 8'h00;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            nack_o   <= 1'b0;
            scl_o    <= 1'b1;
            sda_o    <= 1'b1;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        tx_addr <= {addr_i, rnw_i};
                        tx_data <= wdata_i;
                        rnw     <= rnw_i;
                        nack_o  <= 1'b0;
                        busy_o  <= 1'b1;
                        qcnt    <= '0;
                        quarter <= 2'd0;
                        state   <= START;
                        scl_o   <= 1'b1;
                        sda_o   <= 1'b1;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    if (q_wrap) qcnt <= '0;
                    else if (!stall) qcnt <= qcnt + 1'b1;
                    state   <= nstate;
                    quarter <= nquarter;
                    bit_idx <= nbit;
                    {scl_o, sda_o} <= drive(nstate, nquarter, nsda_bit);
                    // SDA is sampled on the final cycle of the SCL-high Q2 quarter.
                    if (slot && quarter == 2'd2 && q_wrap) begin
                        sda_smp <= sda_i;
                        if (state == DATA && rnw) rx_shift <= {rx_shift[6:0], sda_i};
                    end
                    if (q_wrap && quarter == 2'd3) begin
                        if (state == ADDR_ACK && sda_smp) nack_o <= 1'b1;
                        if (state == DATA_ACK) begin
                            if (rnw) rdata_o <= rx_shift;
                            else if (sda_smp) nack_o <= 1'b1;
                        end
                        if (state == STOP) done_o <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: behavioural I2C slave on the bus plus a quarter-by-quarter
// waveform model whose per-cycle expectations are checked by a single compare process.
module tb_i2c_master;
    localparam int N       = 4;
    localparam int STRETCH = 37;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [6:0] addr_i;
    logic       rnw_i;
    logic [7:0] wdata_i;
    logic [7:0] rdata_o;
    logic       busy_o;
    logic       done_o;
    logic       nack_o;
    logic       scl_i;
    logic       scl_o;
    logic       sda_i;
    logic       sda_o;

    // Slave-side configuration and observations.
    logic       slv_present;
    logic       slv_dack;
    logic       slv_stretch;
    logic [7:0] slv_rbyte;
    logic       slv_hold;
    logic       slv_sda;
    logic       slv_mack;
    int         start_cnt;
    int         stop_cnt;
    logic [7:0] obs_q[$];

    // Scoreboard: one entry per cycle, {busy, done, scl, sda}.
    logic [3:0] exp_q[$];
    logic       mon_on;
    logic [7:0] exp_rdata;
    int         n_checks;
    int         n_pass;

    assign scl_i = scl_o & ~slv_hold;
    assign sda_i = sda_o & slv_sda;

    always #5 clk = ~clk;

    i2c_master #(.CLK_DIV(N)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .start_i (start_i),
        .addr_i  (addr_i),
        .rnw_i   (rnw_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .nack_o  (nack_o),
        .scl_i   (scl_i),
        .scl_o   (scl_o),
        .sda_i   (sda_i),
        .sda_o   (sda_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] obs_at(input int i);
        if (i < obs_q.size()) return {24'h0, obs_q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    // Expected bus waveform: START, address slot bits, ACK, optional data + ACK, STOP,
    // each quarter lasting N cycles, then the DONE cycle and one idle cycle.
    task automatic build_exp(input logic [6:0] a, input logic r, input logic [7:0] w,
                             input logic present, input logic stretch, output int d);
        logic [1:0] qv[$];
        logic [7:0] ab;
        logic       b;
        int         len;
        ab = {a, r};
        qv.push_back(2'b11); qv.push_back(2'b10); qv.push_back(2'b10); qv.push_back(2'b00);
        for (int i = 7; i >= 0; i--)
            for (int p = 0; p < 4; p++) qv.push_back({(p >= 2), ab[i]});
        for (int p = 0; p < 4; p++) qv.push_back({(p >= 2), 1'b1});
        if (present) begin
            for (int i = 7; i >= 0; i--) begin
                b = r ? 1'b1 : w[i];
                for (int p = 0; p < 4; p++) qv.push_back({(p >= 2), b});
            end
            for (int p = 0; p < 4; p++) qv.push_back({(p >= 2), 1'b1});
        end
        qv.push_back(2'b00); qv.push_back(2'b10); qv.push_back(2'b10); qv.push_back(2'b11);
        d = 0;
        for (int j = 0; j < qv.size(); j++) begin
            len = N + ((stretch && j == 22) ? STRETCH : 0);
            for (int c = 0; c < len; c++) exp_q.push_back({2'b10, qv[j]});
            d += len;
        end
        exp_q.push_back(4'b1111);
        exp_q.push_back(4'b0011);
    endtask

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] w,
                           input logic present, input logic dack, input logic [7:0] rb,
                           input logic stretch, input logic pulses, input string tag,
                           output int obase, output int done_cyc);
        int   d;
        int   ndone;
        int   s0;
        int   p0;
        logic exp_nack;
        slv_present = present;
        slv_dack    = dack;
        slv_rbyte   = rb;
        slv_stretch = stretch;
        s0    = start_cnt;
        p0    = stop_cnt;
        obase = obs_q.size();
        build_exp(a, r, w, present, stretch, d);
        @(negedge clk);
        start_i = 1'b1; addr_i = a; rnw_i = r; wdata_i = w;
        @(posedge clk);
        mon_on   = 1'b1;
        done_cyc = -1;
        ndone    = 0;
        for (int k = 1; k <= d + 2; k++) begin
            @(negedge clk);
            start_i = pulses && (k == 100 || k == d + 1);
            if (start_i) begin addr_i = 7'h55; rnw_i = ~r; end
            if (done_o === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = k;
            end
        end
        #1;
        mon_on = 1'b0;
        slv_stretch = 1'b0;
        exp_nack = !present || (!r && !dack);
        if (r && present) exp_rdata = rb;
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_done_cycle"}, done_cyc, d + 1);
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_nack"}, nack_o, exp_nack);
        chk({tag, "_rdata"}, rdata_o, exp_rdata);
        chk({tag, "_starts"}, start_cnt - s0, 1);
        chk({tag, "_stops"}, stop_cnt - p0, 1);
        chk({tag, "_bytes"}, obs_q.size() - obase, present ? 2 : 1);
        chk({tag, "_addr_byte"}, obs_at(obase), {24'h0, a, r});
        if (present) chk({tag, "_data_byte"}, obs_at(obase + 1), {24'h0, (r ? rb : w)});
        if (present && r) chk({tag, "_master_nack"}, slv_mack, 1'b1);
    endtask

    // Compare process: DUT outputs against the expected queue, every cycle of a transaction.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (mon_on && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("bus_busy_done_scl_sda", {busy_o, done_o, scl_o, sda_o}, e);
            end
        end
    end

    // Behavioural slave: decodes START/STOP and bytes on SCL rises, drives on SCL falls.
    initial begin
        logic       ps, pd, cs, cd, rd_mode;
        logic [7:0] shreg;
        int         nbit, hold_left;
        slv_hold = 1'b0; slv_sda = 1'b1; slv_mack = 1'b0;
        ps = 1'b1; pd = 1'b1; rd_mode = 1'b0; shreg = 8'h00; nbit = 0; hold_left = 0;
        forever begin
            @(negedge clk);
            cs = scl_o;
            cd = sda_i;
            if (slv_hold) begin
                hold_left--;
                if (hold_left == 0) slv_hold = 1'b0;
            end
            if (ps && cs && pd && !cd) begin
                start_cnt++;
                nbit = 0;
            end else if (ps && cs && !pd && cd) begin
                stop_cnt++;
            end
            if (!ps && cs) begin
                nbit++;
                shreg = {shreg[6:0], cd};
                if (nbit == 18) slv_mack = cd;
                if (slv_stretch && nbit == 5) begin
                    slv_hold  = 1'b1;
                    hold_left = STRETCH;
                end
            end
            if (ps && !cs) begin
                if (nbit == 8) begin
                    obs_q.push_back(shreg);
                    rd_mode = shreg[0];
                    if (slv_present) slv_sda = 1'b0;
                end else if (nbit == 9) begin
                    slv_sda = (slv_present && rd_mode) ? slv_rbyte[7] : 1'b1;
                end else if (nbit >= 10 && nbit <= 16) begin
                    if (slv_present && rd_mode) slv_sda = slv_rbyte[16 - nbit];
                end else if (nbit == 17) begin
                    obs_q.push_back(shreg);
                    slv_sda = (!rd_mode && slv_present && slv_dack) ? 1'b0 : 1'b1;
                end else if (nbit == 18) begin
                    slv_sda = 1'b1;
                end
            end
            ps = cs;
            pd = cd;
        end
    end

    initial begin
        int         ob, dc, ndone;
        logic [6:0] ra;
        logic [7:0] rw, rr;
        logic       rp, rn, rk, rs, rq;
        n_checks = 0; n_pass = 0; mon_on = 1'b0; exp_rdata = 8'h00;
        start_cnt = 0; stop_cnt = 0;
        slv_present = 1'b0; slv_dack = 1'b0; slv_stretch = 1'b0; slv_rbyte = 8'h00;
        reset_i = 1'b1; start_i = 1'b0; addr_i = 7'h00; rnw_i = 1'b0; wdata_i = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        chk("reset_scl", scl_o, 1'b1);
        chk("reset_sda", sda_o, 1'b1);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_done", done_o, 1'b0);
        chk("reset_nack", nack_o, 1'b0);
        chk("reset_rdata", rdata_o, 8'h00);

        run_txn(7'h20, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, "wr", ob, dc);
        chk("wr_done_lit", dc, 321);
        chk("wr_addr_lit", obs_at(ob), 32'h40);
        chk("wr_data_lit", obs_at(ob + 1), 32'hA5);
        chk("wr_nack_lit", nack_o, 1'b0);

        run_txn(7'h20, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, "rd", ob, dc);
        chk("rd_done_lit", dc, 321);
        chk("rd_addr_lit", obs_at(ob), 32'h41);
        chk("rd_rdata_lit", rdata_o, 8'h3C);

        run_txn(7'h11, 1'b0, 8'h77, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "noack", ob, dc);
        chk("noack_done_lit", dc, 177);
        chk("noack_nack_lit", nack_o, 1'b1);
        chk("noack_rdata_hold", rdata_o, 8'h3C);

        run_txn(7'h20, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, "stretch", ob, dc);
        chk("stretch_done_lit", dc, 321 + STRETCH);

        // Reset while the write data byte is on the bus.
        slv_present = 1'b1; slv_dack = 1'b1;
        @(negedge clk);
        start_i = 1'b1; addr_i = 7'h20; rnw_i = 1'b0; wdata_i = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (199) @(negedge clk);
        chk("pre_reset_busy", busy_o, 1'b1);
        reset_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        exp_rdata = 8'h00;
        chk("midrst_scl", scl_o, 1'b1);
        chk("midrst_sda", sda_o, 1'b1);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_done", done_o, 1'b0);
        chk("midrst_rdata", rdata_o, 8'h00);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o !== 1'b0) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        chk("midrst_idle_busy", busy_o, 1'b0);

        run_txn(7'h20, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, "after_rst", ob, dc);
        chk("after_rst_done_lit", dc, 321);
        chk("after_rst_data_lit", obs_at(ob + 1), 32'h5A);

        run_txn(7'h20, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, "pulses", ob, dc);
        repeat (20) @(negedge clk);
        chk("pulses_stay_idle", {busy_o, scl_o, sda_o}, 3'b011);

        for (int t = 0; t < 8; t++) begin
            ra = 7'($urandom_range(0, 127));
            rn = 1'($urandom_range(0, 1));
            rw = 8'($urandom_range(0, 255));
            rr = 8'($urandom_range(0, 255));
            rp = ($urandom_range(0, 3) != 0);
            rk = ($urandom_range(0, 3) != 0);
            rs = 1'($urandom_range(0, 1));
            rq = 1'($urandom_range(0, 1));
            run_txn(ra, rn, rw, rp, rk, rr, rs, rq, $sformatf("rnd%0d", t), ob, dc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
